// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory read/write sequencers.
// Holds the 3-bit state encodings, the default word width and the
// state-to-strobe decode used by data_mem_read_fsm.
package data_mem_pkg;

   localparam int DATA_SIZE_DFLT = 32;

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_ADDR_READ    = 3'd1;
   localparam logic [2:0] S_MEM_READ     = 3'd2;
   localparam logic [2:0] S_LOAD         = 3'd3;
   localparam logic [2:0] S_DECRYPT      = 3'd4;
   localparam logic [2:0] S_DECRYPT_WAIT = 3'd5;
   localparam logic [2:0] S_PUSH_WAIT    = 3'd6;
   localparam logic [2:0] S_PUSH         = 3'd7;

   typedef struct packed {
      logic addr_pop;
      logic mem_read;
      logic start;
      logic data_push;
   } rd_strobes_t;

   // Strobes are a pure function of the present state so they never glitch
   // on input changes and every unlisted encoding yields all zeros.
   function automatic rd_strobes_t rd_strobes(input logic [2:0] st);
      rd_strobes_t s;
      s = '0;
      case (st)
         S_ADDR_READ: s.addr_pop  = 1'b1;
         S_MEM_READ:  s.mem_read  = 1'b1;
         S_DECRYPT:   s.start     = 1'b1;
         S_PUSH:      s.data_push = 1'b1;
         default:     s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/data_mem_timeout_cnt.sv
// Decrypt-wait watchdog for data_mem_read_fsm.
// Counts cycles the decrypt core reports busy; expired_o fires combinationally
// on the increment that makes the count reach LIMIT. LIMIT must be >= 1.
module data_mem_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear has priority so a fresh wait always starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = inc_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/data_mem_read_fsm.sv
// Read-path sequencer: pops an address, reads ciphertext from data memory,
// runs it through the decrypt core and pushes the plaintext into the
// read-data FIFO. Optional decrypt-wait watchdog: DATA_MEM_RD_TIMEOUT_EN.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// S_IDLE         | wait for address FIFO non-empty and no key setup
// S_ADDR_READ    | pop one read address
// S_MEM_READ     | strobe data memory read
// S_LOAD         | capture ciphertext into data_mem_cipher_in
// S_DECRYPT      | one-cycle start pulse to the decrypt core
// S_DECRYPT_WAIT | wait for busy low, capture plaintext
// S_PUSH_WAIT    | plaintext held, read-data FIFO full
// S_PUSH         | write plaintext, chain to next address if any
import data_mem_pkg::*;

module data_mem_read_fsm #(
   parameter int          data_size      = DATA_SIZE_DFLT,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MRD_addr_fifo_empty,
   output logic                 MRD_addr_fifo_rd_en,
   output logic                 data_mem_read,
   input  logic [data_size-1:0] data_mem_rdata,
   input  logic                 data_mem_initializing_encrypt,
   input  logic                 data_mem_initializing_decrypt,
   output logic [data_size-1:0] data_mem_cipher_in,
   output logic                 data_mem_start_cipher_decrypt,
   input  logic                 data_mem_busy_decrypt,
   input  logic [data_size-1:0] data_mem_plain,
   input  logic                 MRD_data_fifo_full,
   output logic                 MRD_data_fifo_wr_en,
   output logic [data_size-1:0] MRD_data_fifo_din,
   output logic                 rd_timeout_err
);

   logic [2:0]           state_q, state_d;
   logic [data_size-1:0] cipher_q, cipher_d;
   logic [data_size-1:0] din_q, din_d;
   logic                 tmo_expired;
   rd_strobes_t          strb;

`ifdef DATA_MEM_RD_TIMEOUT_EN
   logic err_q;

   data_mem_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q == S_DECRYPT),
      .inc_i     ((state_q == S_DECRYPT_WAIT) && data_mem_busy_decrypt),
      .expired_o (tmo_expired)
   );

   // Error pulse lines up with the first idle cycle after the abandoned wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= tmo_expired;
      end
   end

   assign rd_timeout_err = err_q;
`else
   logic unused_timeout_cycles;

   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign tmo_expired           = 1'b0;
   assign rd_timeout_err        = 1'b0;
`endif

   // Next-state and datapath capture; key setup only gates leaving idle.
   always_comb begin
      state_d  = state_q;
      cipher_d = cipher_q;
      din_d    = din_q;
      case (state_q)
         S_IDLE: begin
            if (!data_mem_initializing_encrypt && !data_mem_initializing_decrypt &&
                !MRD_addr_fifo_empty) begin
               state_d = S_ADDR_READ;
            end
         end
         S_ADDR_READ: state_d = S_MEM_READ;
         S_MEM_READ:  state_d = S_LOAD;
         S_LOAD: begin
            cipher_d = data_mem_rdata;
            state_d  = S_DECRYPT;
         end
         S_DECRYPT:   state_d = S_DECRYPT_WAIT;
         S_DECRYPT_WAIT: begin
            if (!data_mem_busy_decrypt) begin
               din_d   = data_mem_plain;
               state_d = MRD_data_fifo_full ? S_PUSH_WAIT : S_PUSH;
            end else if (tmo_expired) begin
               state_d = S_IDLE;
            end
         end
         S_PUSH_WAIT: begin
            if (!MRD_data_fifo_full) begin
               state_d = S_PUSH;
            end
         end
         S_PUSH:      state_d = MRD_addr_fifo_empty ? S_IDLE : S_ADDR_READ;
         default:     state_d = S_IDLE;
      endcase
   end

   // State and data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cipher_q <= '0;
         din_q    <= '0;
      end else begin
         state_q  <= state_d;
         cipher_q <= cipher_d;
         din_q    <= din_d;
      end
   end

   assign strb                          = rd_strobes(state_q);
   assign MRD_addr_fifo_rd_en           = strb.addr_pop;
   assign data_mem_read                 = strb.mem_read;
   assign data_mem_start_cipher_decrypt = strb.start;
   assign MRD_data_fifo_wr_en           = strb.data_push;
   assign data_mem_cipher_in            = cipher_q;
   assign MRD_data_fifo_din             = din_q;

endmodule

// File: tb/tb_data_mem_read_fsm.sv
// Self-checking bench for data_mem_read_fsm. Build with +define+DATA_MEM_RD_TIMEOUT_EN
// to exercise the decrypt-wait watchdog.
module tb_data_mem_read_fsm;

   localparam int DW  = 32;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          empty = 1'b1;
   logic          rd_en;
   logic          mread;
   logic [DW-1:0] rdata = '0;
   logic          init_enc = 1'b0;
   logic          init_dec = 1'b0;
   logic [DW-1:0] cin;
   logic          start;
   logic          busy = 1'b0;
   logic [DW-1:0] plain = '0;
   logic          full = 1'b0;
   logic          wr;
   logic [DW-1:0] din;
   logic          err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // environment state
   int            addr_cnt = 0;
   int            addr_add = 0;
   bit            rand_mode = 1'b0;
   bit            rand_feed = 1'b0;
   logic [DW-1:0] kn_rdata = '0;
   logic [DW-1:0] kn_plain = '0;
   int            kn_busy = 1;
   int            busy_cnt = 0;
   bit            prev_mread = 1'b0;
   logic [DW-1:0] cur_cipher = '0;
   logic [DW-1:0] cipher_q[$];
   logic [DW-1:0] plain_q[$];
   int            n_pop = 0, n_push = 0, n_err = 0;

   typedef struct {
      logic [DW-1:0] rdata;
      logic [DW-1:0] plain;
      int            busy_len;
      int            full_len;
      int            exp_start;
      int            exp_push;
   } vec_t;

   vec_t vecs[5];

   data_mem_read_fsm #(
      .data_size      (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                           (clk),
      .reset                         (reset),
      .MRD_addr_fifo_empty           (empty),
      .MRD_addr_fifo_rd_en           (rd_en),
      .data_mem_read                 (mread),
      .data_mem_rdata                (rdata),
      .data_mem_initializing_encrypt (init_enc),
      .data_mem_initializing_decrypt (init_dec),
      .data_mem_cipher_in            (cin),
      .data_mem_start_cipher_decrypt (start),
      .data_mem_busy_decrypt         (busy),
      .data_mem_plain                (plain),
      .MRD_data_fifo_full            (full),
      .MRD_data_fifo_wr_en           (wr),
      .MRD_data_fifo_din             (din),
      .rd_timeout_err                (err)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] dec_model(input logic [DW-1:0] c);
      return {c[15:0], c[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Environment: address FIFO occupancy, data memory, decrypt core and
   // transaction scoreboard. Runs 1ns after each negedge so test-process
   // writes made at the negedge are always seen the same cycle.
   initial begin : env
      forever begin
         @(negedge clk); #1;
         if (reset) begin
            busy     = 1'b0;
            busy_cnt = 0;
            cipher_q.delete();
            plain_q.delete();
            addr_cnt += addr_add;
            addr_add = 0;
            empty    = (addr_cnt == 0);
            prev_mread = 1'b0;
         end else begin
            if (rd_en) begin
               chk("pop_while_empty", empty, 0);
               n_pop++;
               if (addr_cnt > 0) addr_cnt--;
            end
            if (wr) begin
               chk("push_while_full", full, 0);
               n_push++;
               chk("push_has_word", plain_q.size() > 0, 1);
               if (plain_q.size() > 0) chk("sb_din", din, plain_q.pop_front());
            end
            if (err) n_err++;
            if (mread) begin
               rdata = rand_mode ? DW'($urandom) : kn_rdata;
               cipher_q.push_back(rdata);
            end else if (!prev_mread) begin
               rdata = DW'($urandom);
            end
            prev_mread = mread;
            if (start) begin
               chk("start_has_cipher", cipher_q.size() > 0, 1);
               if (cipher_q.size() > 0) begin
                  cur_cipher = cipher_q.pop_front();
                  chk("sb_cipher_in", cin, cur_cipher);
               end
               busy     = 1'b1;
               busy_cnt = rand_mode ? int'($urandom_range(1, 6)) : kn_busy;
               plain    = DW'($urandom);
            end else if (busy) begin
               if (busy_cnt > 0) begin
                  busy_cnt--;
               end else begin
                  busy  = 1'b0;
                  plain = rand_mode ? dec_model(cur_cipher) : kn_plain;
                  plain_q.push_back(plain);
               end
            end
            addr_cnt += addr_add;
            addr_add = 0;
            if (rand_mode) begin
               if (rand_feed) begin
                  if ($urandom_range(0, 5) == 0 && addr_cnt < 4) addr_cnt++;
                  full     = ($urandom_range(0, 3) == 0);
                  init_dec = ($urandom_range(0, 15) == 0);
                  init_enc = ($urandom_range(0, 15) == 0);
               end else begin
                  full     = 1'b0;
                  init_dec = 1'b0;
                  init_enc = 1'b0;
               end
            end
            empty = (addr_cnt == 0);
         end
      end
   end

   task automatic quiesce();
      int i;
      i = 0;
      while ((busy || addr_cnt != 0 || addr_add != 0) && i < 600) begin
         @(negedge clk);
         i++;
      end
      if (i >= 600) chk("quiesce_timeout", busy, 0);
      repeat (3) @(negedge clk);
      plain_q.delete();
      cipher_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_mread"}, mread, 0);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_wr_en"}, wr, 0);
      chk({tag, "_err"},   err, 0);
      chk({tag, "_cipher_in"}, cin, 0);
      chk({tag, "_din"},   din, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int fp, fs, fw, nw;
      fp = -1; fs = -1; fw = -1; nw = 0;
      @(negedge clk);
      kn_rdata = v.rdata;
      kn_plain = v.plain;
      kn_busy  = v.busy_len;
      addr_add = 1;
      for (int r = 0; r < v.exp_push + 8; r++) begin
         if (r > 0) @(negedge clk);
         full = (v.full_len > 0) && (r < 5 + v.busy_len + v.full_len);
         if (rd_en && fp < 0) fp = r;
         if (start && fs < 0) begin
            fs = r;
            chk("vec_cipher_in", cin, v.rdata);
         end
         if (wr) begin
            nw++;
            fw = r;
         end
         if (r >= 6 + v.busy_len && r <= v.exp_push) chk("vec_din_hold", din, v.plain);
      end
      full = 1'b0;
      chk("vec_pop_cycle", fp, 1);
      chk("vec_start_cycle", fs, v.exp_start);
      chk("vec_push_cycle", fw, v.exp_push);
      chk("vec_push_count", nw, 1);
   endtask

   initial begin : test
      int fp, fw, nw, ne, fe, p0_pop, p0_push;
      int pops[$];
      int pushes[$];

      // rdata, plain, busy cycles, full cycles at completion, start cycle, push cycle
      vecs[0] = '{32'hDEADBEEF, 32'h12345678, 1, 0, 4, 7};
      vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 1, 0, 4, 7};
      vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 3, 0, 4, 9};
      vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1, 4, 4, 11};
      vecs[4] = '{32'h13579BDF, 32'h2468ACE0, 5, 2, 4, 13};

      // power-on reset
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("post_reset_idle");

      // single-word vectors
      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
         quiesce();
      end

      // key setup holds idle for 10 cycles; raising it mid-word has no effect
      kn_rdata = 32'hCAFEF00D; kn_plain = 32'h0BADC0DE; kn_busy = 1;
      fp = -1; fw = -1; nw = 0;
      @(negedge clk);
      init_dec = 1'b1;
      addr_add = 1;
      for (int r = 0; r < 26; r++) begin
         if (r > 0) @(negedge clk);
         if (r == 10) init_dec = 1'b0;
         if (r == 15) init_enc = 1'b1;
         if (rd_en && fp < 0) fp = r;
         if (wr) begin nw++; fw = r; end
      end
      init_enc = 1'b0;
      chk("init_pop_cycle", fp, 11);
      chk("init_push_cycle", fw, 17);
      chk("init_push_count", nw, 1);
      quiesce();

      // three queued addresses run back to back
      kn_rdata = 32'h01234567; kn_plain = 32'h89ABCDEF; kn_busy = 1;
      pops.delete(); pushes.delete();
      @(negedge clk);
      addr_add = 3;
      for (int r = 0; r < 32; r++) begin
         if (r > 0) @(negedge clk);
         if (rd_en) pops.push_back(r);
         if (wr) pushes.push_back(r);
      end
      chk("b2b_pop_count", pops.size(), 3);
      chk("b2b_push_count", pushes.size(), 3);
      if (pops.size() == 3 && pushes.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("b2b_pop_cycle", pops[k], 1 + 7 * k);
            chk("b2b_push_cycle", pushes[k], 7 + 7 * k);
         end
      end
      quiesce();

      // reset while waiting on the decrypt core
      kn_rdata = 32'h11112222; kn_plain = 32'h33334444; kn_busy = 20;
      p0_push = n_push;
      @(negedge clk);
      addr_add = 1;
      for (int r = 0; r < 8; r++) begin
         if (r > 0) @(negedge clk);
         if (r == 6) reset = 1'b1;
      end
      check_outputs_zero("midop_reset");
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("midop_reset_no_push", n_push - p0_push, 0);
      quiesce();

      // decrypt core stuck busy for 300 cycles
      kn_rdata = 32'h55556666; kn_plain = 32'h77778888; kn_busy = 300;
      fw = -1; nw = 0; ne = 0; fe = -1;
      @(negedge clk);
      addr_add = 1;
      for (int r = 0; r < 340; r++) begin
         if (r > 0) @(negedge clk);
         if (wr) begin nw++; fw = r; end
         if (err) begin ne++; if (fe < 0) fe = r; end
      end
`ifdef DATA_MEM_RD_TIMEOUT_EN
      chk("tmo_err_count", ne, 1);
      chk("tmo_err_cycle", fe, 260);
      chk("tmo_no_push", nw, 0);
`else
      chk("notmo_err_count", ne, 0);
      chk("notmo_push_cycle", fw, 306);
      chk("notmo_push_count", nw, 1);
`endif
      quiesce();

      // randomized traffic against the transaction scoreboard
      p0_pop = n_pop; p0_push = n_push;
      rand_mode = 1'b1;
      rand_feed = 1'b1;
      repeat (3000) @(negedge clk);
      rand_feed = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (addr_cnt == 0 && !busy && (n_push - p0_push) == (n_pop - p0_pop)) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("rand_pops_eq_pushes", n_push - p0_push, n_pop - p0_pop);
      chk("rand_enough_traffic", (n_pop - p0_pop) > 50, 1);
      chk("rand_sb_plain_empty", plain_q.size(), 0);
      chk("rand_sb_cipher_empty", cipher_q.size(), 0);
      chk("rand_no_err", n_err, 0);
      rand_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
